// File: rtl/prog_mem_loadable.sv
// prog_mem_loadable: DEPTH x DATA_W program store for the 8-bit CPU.
// It has a registered read-first fetch port and a framed byte-stream loader.
// A frame is: HDR_BYTE, start address, word count N, then N*BYTES data bytes (LSB first).
// Optional build macro PROG_MEM_CHECKSUM_EN adds a trailing 8-bit sum byte.
// The sum covers the address, count and data bytes. A wrong sum raises ld_err.
module prog_mem_loadable #(
    parameter int         DEPTH    = 64,
    parameter int         DATA_W   = 8,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic                     ld_valid,
    input  logic [7:0]               ld_data,
    output logic                     ld_ready,
    output logic                     ld_busy,
    output logic                     ld_done,
    output logic                     ld_err,
    output logic [7:0]               ld_count
);
    localparam int         ADDR_W = $clog2(DEPTH);
    localparam int         BYTES  = DATA_W / 8;
    localparam logic [1:0] LAST_B = 2'(BYTES - 1);

`ifdef PROG_MEM_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CHK, DONE} state_t;
    localparam state_t TAIL_ST = CHK;
`else
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, DONE} state_t;
    localparam state_t TAIL_ST = DONE;
`endif

    state_t              state, state_nx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   ptr;
    logic [1:0]          bidx;
    logic [7:0]          remaining;
    logic [DATA_W-1:0]   asm_word;
    logic [DATA_W-1:0]   wr_word;
    logic                mem_we;
    logic                xfer;
    logic                word_last;

    assign ld_ready  = rst_n && (state != DONE);
    assign xfer      = ld_valid && ld_ready;
    assign ld_busy   = (state != IDLE) && (state != DONE);
    assign ld_done   = (state == DONE);
    assign word_last = (bidx == LAST_B);

`ifdef PROG_MEM_CHECKSUM_EN
    logic [7:0] sum;
    logic       err;
    assign ld_err = err;
`else
    assign ld_err = 1'b0;
`endif

    // Loader state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode, word assembly and write strobe
    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        wr_word  = asm_word;
        for (int b = 0; b < BYTES; b++) begin
            if (b == int'(bidx)) wr_word[b*8 +: 8] = ld_data;
        end
        if (xfer) begin
            case (state)
                IDLE: if (ld_data == HDR_BYTE) state_nx = ADDR;
                ADDR: state_nx = LEN;
                LEN:  state_nx = (ld_data == 8'd0) ? TAIL_ST : DATA;
                DATA: begin
                    if (word_last) begin
                        mem_we = 1'b1;
                        if (remaining == 8'd1) state_nx = TAIL_ST;
                    end
                end
`ifdef PROG_MEM_CHECKSUM_EN
                CHK:  state_nx = DONE;
`endif
                default: ;
            endcase
        end
        if (state == DONE) state_nx = IDLE;
    end

    // Frame control: write pointer, byte index, words left, word count, error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            bidx      <= 2'd0;
            remaining <= 8'd0;
            ld_count  <= 8'd0;
`ifdef PROG_MEM_CHECKSUM_EN
            err       <= 1'b0;
`endif
        end else if (xfer) begin
            case (state)
                IDLE: begin
                    if (ld_data == HDR_BYTE) begin
                        ld_count <= 8'd0;
`ifdef PROG_MEM_CHECKSUM_EN
                        err      <= 1'b0;
`endif
                    end
                end
                ADDR: ptr <= ld_data[ADDR_W-1:0];
                LEN: begin
                    remaining <= ld_data;
                    bidx      <= 2'd0;
                end
                DATA: begin
                    if (word_last) begin
                        bidx      <= 2'd0;
                        ptr       <= ptr + 1'b1;
                        ld_count  <= ld_count + 8'd1;
                        remaining <= remaining - 8'd1;
                    end else begin
                        bidx <= bidx + 2'd1;
                    end
                end
`ifdef PROG_MEM_CHECKSUM_EN
                CHK: err <= (ld_data != sum);
`endif
                default: ;
            endcase
        end
    end

    // Partial-word holding register and running checksum (no reset needed: reloaded per frame)
    always_ff @(posedge clk) begin
        if (xfer && state == DATA) asm_word <= wr_word;
`ifdef PROG_MEM_CHECKSUM_EN
        if (xfer && state == ADDR) sum <= ld_data;
        if (xfer && (state == LEN || state == DATA)) sum <= sum + ld_data;
`endif
    end

    // Program store with registered read-first fetch port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)  rd_data  <= mem[rd_addr];
            if (mem_we) mem[ptr] <= wr_word;
        end
    end
endmodule

// File: tb/tb_prog_mem_loadable.sv
// Self-checking bench for prog_mem_loadable: an 8-bit x 64 instance with random frames,
// plus a 16-bit x 16 instance for word assembly and read/write collision.
module tb_prog_mem_loadable;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready, ld_busy, ld_done, ld_err;
    logic [7:0]  ld_count;

    logic        rd_en16 = 1'b0;
    logic [3:0]  rd_addr16 = '0;
    logic [15:0] rd_data16;
    logic        rd_valid16;
    logic        ld_valid16 = 1'b0;
    logic [7:0]  ld_data16 = '0;
    logic        ld_ready16, ld_busy16, ld_done16, ld_err16;
    logic [7:0]  ld_count16;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model [DEPTH];
    int          done_cnt = 0;
    int          done16_cnt = 0;
    logic        err_at_done = 1'b0;
    logic        ready_at_done = 1'b0;

    prog_mem_loadable #(.DEPTH(64), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err), .ld_count(ld_count));

    prog_mem_loadable #(.DEPTH(16), .DATA_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en16), .rd_addr(rd_addr16), .rd_data(rd_data16),
        .rd_valid(rd_valid16), .ld_valid(ld_valid16), .ld_data(ld_data16), .ld_ready(ld_ready16),
        .ld_busy(ld_busy16), .ld_done(ld_done16), .ld_err(ld_err16), .ld_count(ld_count16));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ld_done) begin
            done_cnt++;
            err_at_done   = ld_err;
            ready_at_done = ld_ready;
        end
        if (ld_done16) done16_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = b;
        while (!ld_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (g >= 10) check("ready_timeout", 32'(ld_ready), 32'd1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic read_check(input int a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        check({tag, "_vld_idle"}, 32'(rd_valid), 32'd0);
        rd_en   = 1'b1;
        rd_addr = 6'(a);
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_vld"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) read_check(i, model[i], tag);
    endtask

    // Sends one complete frame, updates the model and checks the frame-level outputs.
    task automatic send_frame(input logic [7:0] addr_b, input logic [7:0] bytes[$],
                              input bit corrupt, input bit gaps);
        logic [7:0] sum;
        logic [7:0] n8;
        bit         exp_err;
        int         base_done;
        int         g = 0;
        n8        = 8'(bytes.size());
        sum       = addr_b + n8;
        base_done = done_cnt;
        send_byte(8'hA5, gaps);
        check("busy_after_hdr", 32'(ld_busy), 32'd1);
        check("count_clr_on_hdr", 32'(ld_count), 32'd0);
        check("err_clr_on_hdr", 32'(ld_err), 32'd0);
        send_byte(addr_b, gaps);
        send_byte(n8, gaps);
        foreach (bytes[i]) begin
            send_byte(bytes[i], gaps);
            sum = sum + bytes[i];
            model[(int'(addr_b) + i) % DEPTH] = bytes[i];
        end
`ifdef PROG_MEM_CHECKSUM_EN
        send_byte(corrupt ? sum + 8'd1 : sum, gaps);
        exp_err = corrupt;
`else
        exp_err = 1'b0;
`endif
        while (done_cnt == base_done && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("done_seen", 32'(done_cnt - base_done), 32'd1);
        check("ready_low_in_done", 32'(ready_at_done), 32'd0);
        check("err_at_done", 32'(err_at_done), 32'(exp_err));
        check("count", 32'(ld_count), 32'(n8));
        @(negedge clk);
        check("busy_after_done", 32'(ld_busy), 32'd0);
        check("err_held", 32'(ld_err), 32'(exp_err));
    endtask

    task automatic send16(input logic [7:0] b);
        int g = 0;
        @(negedge clk);
        ld_valid16 = 1'b1;
        ld_data16  = b;
        while (!ld_ready16 && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (g >= 10) check("ready16_timeout", 32'(ld_ready16), 32'd1);
        @(posedge clk);
        #1;
        ld_valid16 = 1'b0;
    endtask

    task automatic read16(input logic [3:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        rd_en16   = 1'b1;
        rd_addr16 = a;
        @(negedge clk);
        rd_en16 = 1'b0;
        check({tag, "_vld"}, 32'(rd_valid16), 32'd1);
        check(tag, 32'(rd_data16), 32'(exp));
    endtask

    task automatic wait_done16(input int base);
        int g = 0;
        while (done16_cnt == base && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("done16_seen", 32'(done16_cnt - base), 32'd1);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        int         n;
        int         base;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

        // Reset state
        #2;
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_busy", 32'(ld_busy), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_err", 32'(ld_err), 32'd0);
        check("rst_count", 32'(ld_count), 32'd0);
        check("rst_rvalid", 32'(rd_valid), 32'd0);
        check("rst_rdata", 32'(rd_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(ld_ready), 32'd1);
        sweep("rst_mem");

        // Directed frame: 3 words at 0x10
        q = {8'h11, 8'h22, 8'h33};
        send_frame(8'h10, q, 1'b0, 1'b0);
        read_check(16, 8'h11, "a_mem10");
        read_check(17, 8'h22, "a_mem11");
        read_check(18, 8'h33, "a_mem12");
        @(negedge clk);
        check("rd_hold", 32'(rd_data), 32'h33);

        // Junk byte dropped, then wrapping frame at 0x3E
        send_byte(8'h5A, 1'b0);
        check("junk_not_busy", 32'(ld_busy), 32'd0);
        q = {8'hAA, 8'hBB, 8'hCC};
        send_frame(8'h3E, q, 1'b0, 1'b0);
        read_check(62, 8'hAA, "b_mem3e");
        read_check(63, 8'hBB, "b_mem3f");
        read_check(0, 8'hCC, "b_mem00");

`ifdef PROG_MEM_CHECKSUM_EN
        // Checksum good, then bad, then cleared by the next header
        q = {8'h7F};
        send_frame(8'h02, q, 1'b0, 1'b0);
        read_check(2, 8'h7F, "c_mem02");
        send_frame(8'h02, q, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(ld_err), 32'd1);
`endif

        // Randomized frames with junk, gaps, random length and occasional oversize
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h3C;
                send_byte(b, 1'b1);
            end
            n = (f == 3) ? 70 : $urandom_range(0, 12);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
            send_frame(8'($urandom_range(0, 255)), q, 1'($urandom_range(0, 1)), 1'b1);
        end
        sweep("rand_mem");

        // Reset in the middle of a frame
        send_byte(8'hA5, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        check("mid_busy", 32'(ld_busy), 32'd1);
        check("mid_count", 32'(ld_count), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(ld_busy), 32'd0);
        check("arst_ready", 32'(ld_ready), 32'd0);
        check("arst_count", 32'(ld_count), 32'd0);
        check("arst_rvalid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        read_check(5, 8'h00, "arst_mem05");
        q = {8'h44, 8'h55};
        send_frame(8'h05, q, 1'b0, 1'b0);
        read_check(5, 8'h44, "d_mem05");
        read_check(6, 8'h55, "d_mem06");
        sweep("final_mem");

        // 16-bit words: little-endian assembly and read-first collision
        base = done16_cnt;
        send16(8'hA5);
        send16(8'h00);
        send16(8'h01);
        send16(8'h34);
        @(negedge clk);
        ld_valid16 = 1'b1;
        ld_data16  = 8'h12;
        rd_en16    = 1'b1;
        rd_addr16  = 4'd0;
        check("w16_ready", 32'(ld_ready16), 32'd1);
        @(posedge clk);
        #1;
        ld_valid16 = 1'b0;
        rd_en16    = 1'b0;
        check("w16_coll_vld", 32'(rd_valid16), 32'd1);
        check("w16_coll_old", 32'(rd_data16), 32'h0000);
`ifdef PROG_MEM_CHECKSUM_EN
        send16(8'h47);
`endif
        wait_done16(base);
        check("w16_count", 32'(ld_count16), 32'd1);
        read16(4'd0, 16'h1234, "w16_mem0");

        base = done16_cnt;
        send16(8'hA5);
        send16(8'h0F);
        send16(8'h02);
        send16(8'h01);
        send16(8'h02);
        send16(8'h03);
        send16(8'h04);
`ifdef PROG_MEM_CHECKSUM_EN
        send16(8'h1B);
`endif
        wait_done16(base);
        check("w16_count2", 32'(ld_count16), 32'd2);
        check("w16_err", 32'(ld_err16), 32'd0);
        read16(4'd15, 16'h0201, "w16_mem15");
        read16(4'd0, 16'h0403, "w16_mem0_wrap");
        read16(4'd1, 16'h0000, "w16_mem1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
